// File: rtl/tbird_lights_param.sv
// Thunderbird tail-light sequencer: N_LAMPS lamps per side, a step prescaler,
// and a brake overlay on top of the registered turn/hazard pattern.
module tbird_lights_param #(
  parameter int N_LAMPS = 3,
  parameter int DIV     = 1
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               left,
  input  logic               right,
  input  logic               haz,
  input  logic               brake,
  output logic [N_LAMPS-1:0] l_lights,
  output logic [N_LAMPS-1:0] r_lights,
  output logic               busy
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {IDLE, TURN_L, TURN_R, HAZ} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               tick;
  logic [N_LAMPS-1:0] l_pat;
  logic [N_LAMPS-1:0] r_pat;

  assign tick = (cnt == CW'(DIV - 1));

  // The lamp pattern is a thermometer code, so its top bit marks the last step.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= IDLE;
      cnt   <= '0;
      l_pat <= '0;
      r_pat <= '0;
      busy  <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) begin
        unique case (state)
          IDLE: begin
            if (haz || (left && right)) begin
              state <= HAZ;
              l_pat <= '1;
              r_pat <= '1;
              busy  <= 1'b1;
            end else if (left) begin
              state <= TURN_L;
              l_pat <= N_LAMPS'(1);
              busy  <= 1'b1;
            end else if (right) begin
              state <= TURN_R;
              r_pat <= N_LAMPS'(1);
              busy  <= 1'b1;
            end
          end
          TURN_L: begin
            if (haz) begin
              state <= HAZ;
              l_pat <= '1;
              r_pat <= '1;
            end else if (l_pat[N_LAMPS-1]) begin
              state <= IDLE;
              l_pat <= '0;
              busy  <= 1'b0;
            end else begin
              l_pat <= {l_pat[N_LAMPS-2:0], 1'b1};
            end
          end
          TURN_R: begin
            if (haz) begin
              state <= HAZ;
              l_pat <= '1;
              r_pat <= '1;
            end else if (r_pat[N_LAMPS-1]) begin
              state <= IDLE;
              r_pat <= '0;
              busy  <= 1'b0;
            end else begin
              r_pat <= {r_pat[N_LAMPS-2:0], 1'b1};
            end
          end
          HAZ: begin
            state <= IDLE;
            l_pat <= '0;
            r_pat <= '0;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            l_pat <= '0;
            r_pat <= '0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Brake lights every side not turning; gated by rst_b so reset blanks all lamps at once.
  assign l_lights = l_pat | {N_LAMPS{brake && rst_b && (state != TURN_L)}};
  assign r_lights = r_pat | {N_LAMPS{brake && rst_b && (state != TURN_R)}};

endmodule

// File: tb/tb_tbird_lights_param.sv
// Scoreboard bench: two instances (N=3/DIV=1 and N=4/DIV=4) share random inputs;
// an abstract lamp model queues expected outputs, a monitor pops and compares.
module tb_tbird_lights_param;

  logic       clk;
  logic       rst_b;
  logic       left, right, haz, brake;
  logic [2:0] l0, r0;
  logic [3:0] l1, r1;
  logic       busy0, busy1;

  typedef struct {
    int l0, r0, l1, r1, b0, b1;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   running = 0;

  // Abstract model per instance: mode 0=idle 1=left 2=right 3=hazard, k = lamps lit.
  int m_n[2]   = '{3, 4};
  int m_div[2] = '{1, 4};
  int m_cnt[2];
  int m_mode[2];
  int m_k[2];

  tbird_lights_param #(.N_LAMPS(3), .DIV(1)) dut0 (
    .clk(clk), .rst_b(rst_b), .left(left), .right(right), .haz(haz),
    .brake(brake), .l_lights(l0), .r_lights(r0), .busy(busy0)
  );

  tbird_lights_param #(.N_LAMPS(4), .DIV(4)) dut1 (
    .clk(clk), .rst_b(rst_b), .left(left), .right(right), .haz(haz),
    .brake(brake), .l_lights(l1), .r_lights(r1), .busy(busy1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i]  = 0;
      m_mode[i] = 0;
      m_k[i]    = 0;
    end
  endtask

  task automatic model_step(input logic l, input logic r, input logic h);
    for (int i = 0; i < 2; i++) begin
      bit t;
      t = (m_cnt[i] == m_div[i] - 1);
      m_cnt[i] = (m_cnt[i] + 1) % m_div[i];
      if (t) begin
        case (m_mode[i])
          0: begin
            if (h || (l && r)) m_mode[i] = 3;
            else if (l) begin m_mode[i] = 1; m_k[i] = 1; end
            else if (r) begin m_mode[i] = 2; m_k[i] = 1; end
          end
          1, 2: begin
            if (h) m_mode[i] = 3;
            else if (m_k[i] == m_n[i]) m_mode[i] = 0;
            else m_k[i]++;
          end
          default: m_mode[i] = 0;
        endcase
      end
    end
  endtask

  function automatic void model_lamps(input int i, input logic b,
                                      output int lp, output int rp, output int bz);
    int all;
    all = (1 << m_n[i]) - 1;
    lp = 0;
    rp = 0;
    if (m_mode[i] == 1) lp = (1 << m_k[i]) - 1;
    if (m_mode[i] == 2) rp = (1 << m_k[i]) - 1;
    if (m_mode[i] == 3) begin lp = all; rp = all; end
    if (b && m_mode[i] != 1) lp = all;
    if (b && m_mode[i] != 2) rp = all;
    bz = (m_mode[i] != 0) ? 1 : 0;
  endfunction

  // One clock of stimulus: drive at the falling edge and queue what the next rising edge must show.
  task automatic apply_stimulus(input logic l, input logic r, input logic h,
                                input logic b, input logic in_reset);
    exp_t e;
    @(negedge clk);
    left  = l;
    right = r;
    haz   = h;
    brake = b;
    if (in_reset) begin
      rst_b = 1'b0;
      model_reset();
      e = '{0, 0, 0, 0, 0, 0};
    end else begin
      if (!rst_b) begin
        rst_b = 1'b1;
        model_reset();
      end
      model_step(l, r, h);
      model_lamps(0, b, e.l0, e.r0, e.b0);
      model_lamps(1, b, e.l1, e.r1, e.b1);
    end
    exp_q.push_back(e);
    running = 1'b1;
  endtask

  always @(posedge clk) begin
    #1;
    if (running) begin
      if (exp_q.size() == 0) begin
        check_output("queue_underflow", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_output("l_lights_n3", int'(l0), e.l0);
        check_output("r_lights_n3", int'(r0), e.r0);
        check_output("busy_n3", int'(busy0), e.b0);
        check_output("l_lights_n4", int'(l1), e.l1);
        check_output("r_lights_n4", int'(r1), e.r1);
        check_output("busy_n4", int'(busy1), e.b1);
      end
    end
  end

  typedef struct {
    logic l, r, h, b;
    int   len;
  } dir_t;

  dir_t dirs[8] = '{
    '{1'b0, 1'b0, 1'b0, 1'b0, 3},
    '{1'b0, 1'b1, 1'b0, 1'b0, 10},
    '{1'b1, 1'b0, 1'b0, 1'b0, 1},
    '{1'b0, 1'b0, 1'b1, 1'b0, 2},
    '{1'b1, 1'b1, 1'b0, 1'b0, 8},
    '{1'b1, 1'b0, 1'b0, 1'b0, 24},
    '{1'b0, 1'b1, 1'b0, 1'b1, 12},
    '{1'b0, 1'b0, 1'b0, 1'b1, 3}
  };

  initial begin
    logic l, r, h, b;
    rst_b = 1'b0;
    left  = 1'b0;
    right = 1'b0;
    haz   = 1'b0;
    brake = 1'b0;
    model_reset();

    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    foreach (dirs[d])
      for (int i = 0; i < dirs[d].len; i++)
        apply_stimulus(dirs[d].l, dirs[d].r, dirs[d].h, dirs[d].b, 1'b0);

    l = 1'b0; r = 1'b0; h = 1'b0; b = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(3) == 0) begin
        l = ($urandom_range(9) < 4);
        r = ($urandom_range(9) < 3);
        h = ($urandom_range(9) < 1);
        b = ($urandom_range(9) < 3);
      end
      if (c == 300) begin
        // Mid-sequence asynchronous reset with brake held: lamps must drop before any edge.
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        #2;
        check_output("async_reset_l_n3", int'(l0), 0);
        check_output("async_reset_r_n3", int'(r0), 0);
        check_output("async_reset_l_n4", int'(l1), 0);
        check_output("async_reset_r_n4", int'(r1), 0);
        check_output("async_reset_busy", int'(busy0 | busy1), 0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      end else begin
        apply_stimulus(l, r, h, b, 1'b0);
      end
    end

    @(posedge clk);
    #2;
    check_output("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
